// File: rtl/coin_pulse_conditioner.sv
// Coin-slot front end: synchronise, debounce, hold coins during dispense, reject ambiguity/overflow.
// Optional COIN_AUDIT_EN adds saturating total5/total10/rejects counters.
`timescale 1ns/1ps
module coin_pulse_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       dispense,
    output logic       coin5,
    output logic       coin10,
    output logic       coin_reject,
    output logic       pending
`ifdef COIN_AUDIT_EN
   ,output logic [7:0] total5,
    output logic [7:0] total10,
    output logic [7:0] rejects
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} ch_state_e;

    logic [1:0]       sync5, sync10;
    logic [1:0]       s_c;
    logic [1:0]       ev_c;
    ch_state_e        st_q  [2];
    ch_state_e        st_d  [2];
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic slot_type;
    logic coin5_d, coin10_d, reject_d, slot_valid_d, slot_type_d, release_c;

    // Two-flop synchronisers; bit 0 = coin5, bit 1 = coin10
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync5  <= '0;
            sync10 <= '0;
        end else begin
            sync5  <= {sync5[0], coin5_raw};
            sync10 <= {sync10[0], coin10_raw};
        end
    end

    assign s_c = {sync10[1], sync5[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Debounce FSMs; the press event is combinational so the registered output lands at k+D+2
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            ev_c[i]  = 1'b0;
            unique case (st_q[i])
                IDLE: begin
                    if (s_c[i]) begin
                        st_d[i]  = PRESS_CHK;
                        cnt_d[i] = CNT_W'(1);
                    end
                end
                PRESS_CHK: begin
                    if (!s_c[i]) begin
                        st_d[i]  = IDLE;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                        st_d[i]  = HELD;
                        cnt_d[i] = '0;
                        ev_c[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!s_c[i]) begin
                        st_d[i]  = REL_CHK;
                        cnt_d[i] = CNT_W'(1);
                    end
                end
                REL_CHK: begin
                    if (s_c[i]) begin
                        st_d[i]  = HELD;
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                        st_d[i]  = IDLE;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    st_d[i]  = IDLE;
                    cnt_d[i] = '0;
                end
            endcase
        end
    end

    // Slot arbitration; a release and a new store may share a cycle so the slot never looks free twice
    always_comb begin
        coin5_d      = 1'b0;
        coin10_d     = 1'b0;
        reject_d     = 1'b0;
        slot_valid_d = pending;
        slot_type_d  = slot_type;
        release_c    = pending && !dispense;

        if (release_c) begin
            coin5_d      = !slot_type;
            coin10_d     = slot_type;
            slot_valid_d = 1'b0;
        end

        if (ev_c == 2'b11) begin
            reject_d = 1'b1;
        end else if (ev_c != 2'b00) begin
            if (!pending && !dispense) begin
                coin5_d  = ev_c[0];
                coin10_d = ev_c[1];
            end else if (!pending || release_c) begin
                slot_valid_d = 1'b1;
                slot_type_d  = ev_c[1];
            end else begin
                reject_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin5       <= 1'b0;
            coin10      <= 1'b0;
            coin_reject <= 1'b0;
            pending     <= 1'b0;
            slot_type   <= 1'b0;
        end else begin
            coin5       <= coin5_d;
            coin10      <= coin10_d;
            coin_reject <= reject_d;
            pending     <= slot_valid_d;
            slot_type   <= slot_type_d;
        end
    end

`ifdef COIN_AUDIT_EN
    // Saturating counts of issued pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total5  <= '0;
            total10 <= '0;
            rejects <= '0;
        end else begin
            if (coin5 && total5 != 8'hFF)         total5  <= total5 + 8'd1;
            if (coin10 && total10 != 8'hFF)       total10 <= total10 + 8'd1;
            if (coin_reject && rejects != 8'hFF)  rejects <= rejects + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Scoreboard bench for coin_pulse_conditioner: directed stimulus pushes expected pulses, a monitor checks them.
`timescale 1ns/1ps
module tb_coin_pulse_conditioner;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  v;      // {coin_reject, coin10, coin5}
    } exp_t;

    typedef struct {
        int unsigned cyc;
        logic        v;
    } pend_t;

    logic clk = 1'b0;
    logic rst, coin5_raw, coin10_raw, dispense;
    logic coin5, coin10, coin_reject, pending;
`ifdef COIN_AUDIT_EN
    logic [7:0] total5, total10, rejects;
`endif

    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        done = 1'b0;
    exp_t        exp_q [$];
    pend_t       pend_q [$];
    logic [2:0]  obs;
    exp_t        e;
    pend_t       p;
    logic [4:0]  bounce;

    coin_pulse_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .dispense   (dispense),
        .coin5      (coin5),
        .coin10     (coin10),
        .coin_reject(coin_reject),
        .pending    (pending)
`ifdef COIN_AUDIT_EN
       ,.total5     (total5),
        .total10    (total10),
        .rejects    (rejects)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_pulse(input int unsigned c, input logic [2:0] v);
        exp_t x;
        x.cyc = c;
        x.v   = v;
        exp_q.push_back(x);
    endtask

    task automatic exp_pend(input logic v);
        pend_t x;
        x.cyc = cyc;
        x.v   = v;
        pend_q.push_back(x);
    endtask

    // Monitor: sole checker; samples on the falling edge
    always @(negedge clk) begin
        obs = {coin_reject, coin10, coin5};
        if (obs != 3'b000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, obs);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v != obs) begin
                    miscompares++;
                    $display("FAIL pulse cyc=%0d got=%b required=%b@cyc%0d", cyc, obs, e.v, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missing_pulse cyc=%0d got=000 required=%b", cyc, e.v);
        end

        if (pend_q.size() != 0 && pend_q[0].cyc == cyc) begin
            p = pend_q.pop_front();
            vectors++;
            if (pending !== p.v) begin
                miscompares++;
                $display("FAIL pending cyc=%0d got=%b required=%b", cyc, pending, p.v);
            end
        end

        if (done) begin
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL never_seen got=none required=%b@cyc%0d", e.v, e.cyc);
            end
            while (pend_q.size() != 0) begin
                p = pend_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL pending_unchecked got=none required=%b@cyc%0d", p.v, p.cyc);
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        dispense   = 1'b0;
        tick(2);
        exp_pend(1'b0);
        tick(1);
        rst = 1'b0;
        tick(3);
        exp_pend(1'b0);

        // Clean coin5 press held 20 cycles: one pulse at set-edge + 6
        coin5_raw = 1'b1;
        exp_pulse(cyc + 7, 3'b001);
        tick(20);
        coin5_raw = 1'b0;
        tick(10);

        // Bouncy coin10: 1,0,1,1,0 then steady high
        bounce = 5'b10110;
        for (int i = 4; i >= 0; i--) begin
            coin10_raw = bounce[i];
            tick(1);
        end
        coin10_raw = 1'b1;
        exp_pulse(cyc + 7, 3'b010);
        tick(12);
        // Three low cycles are too short to release: no second pulse
        coin10_raw = 1'b0;
        tick(3);
        coin10_raw = 1'b1;
        tick(10);
        coin10_raw = 1'b0;
        tick(10);
        coin10_raw = 1'b1;
        exp_pulse(cyc + 7, 3'b010);
        tick(12);
        coin10_raw = 1'b0;
        tick(10);

        // Held during dispense, issued when dispense drops
        dispense   = 1'b1;
        coin10_raw = 1'b1;
        tick(10);
        exp_pend(1'b1);
        coin10_raw = 1'b0;
        tick(10);
        dispense = 1'b0;
        exp_pulse(cyc + 1, 3'b010);
        tick(1);
        exp_pend(1'b0);
        tick(5);

        // Overflow: second coin rejected, first kept
        dispense  = 1'b1;
        coin5_raw = 1'b1;
        tick(10);
        coin5_raw = 1'b0;
        tick(10);
        exp_pend(1'b1);
        coin10_raw = 1'b1;
        exp_pulse(cyc + 7, 3'b100);
        tick(10);
        coin10_raw = 1'b0;
        tick(10);
        exp_pend(1'b1);
        dispense = 1'b0;
        exp_pulse(cyc + 1, 3'b001);
        tick(2);
        exp_pend(1'b0);
        tick(5);

        // Simultaneous press: reject only, slot untouched
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        exp_pulse(cyc + 7, 3'b100);
        tick(10);
        exp_pend(1'b0);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        tick(10);

        // Reset with slot full and coin10 mid-debounce (cnt=2)
        dispense  = 1'b1;
        coin5_raw = 1'b1;
        tick(10);
        coin5_raw = 1'b0;
        tick(10);
        exp_pend(1'b1);
        coin10_raw = 1'b1;
        tick(4);
        rst = 1'b1;
        exp_pend(1'b0);
        tick(3);
        dispense = 1'b0;
        rst      = 1'b0;
        exp_pulse(cyc + 7, 3'b010);
        tick(12);
        exp_pend(1'b0);
        coin10_raw = 1'b0;
        tick(10);

        done = 1'b1;
    end

endmodule

// File: doc/coin_pulse_conditioner.md
Name: coin_pulse_conditioner

Overview:
Upstream front-end for the vending FSM. It synchronises and debounces the raw coin-slot sensors and emits clean one-cycle coin5/coin10 pulses. Coins that arrive while the FSM is dispensing are held in a one-deep slot and released after dispense drops. Ambiguous or overflowing coins are rejected with a pulse.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised-high (or low) cycles needed to accept a press (or release); legal range >= 1
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
coin5_raw  input  1  raw 5-unit slot sensor; asynchronous, bouncy
coin10_raw  input  1  raw 10-unit slot sensor; asynchronous, bouncy
dispense  input  1  downstream FSM dispense flag; coins are held while high
coin5  output  1  one-cycle accepted 5-unit pulse to FSM
coin10  output  1  one-cycle accepted 10-unit pulse to FSM
coin_reject  output  1  one-cycle pulse; coin discarded (simultaneous or slot overflow)
pending  output  1  high while a held coin occupies the slot

Behaviour:
- Reset: sync flops 0, both channel FSMs IDLE, counters 0, slot empty. coin5, coin10, coin_reject and pending are all 0. Reset mid-debounce or with a held coin discards everything; no pulse follows reset release until a fresh full debounce completes.
- Sync: each raw input passes through a 2-flop synchroniser to give s5/s10.
- Per-channel FSM, identical for both channels:
  - IDLE: s=1 -> PRESS_CHK, cnt=1; else stay.
  - PRESS_CHK: s=0 -> IDLE, cnt=0. s=1 and cnt==DEBOUNCE_CYCLES -> HELD and raise a one-cycle event. Else cnt++.
  - HELD: s=0 -> REL_CHK, cnt=1.
  - REL_CHK: s=1 -> HELD. s=0 and cnt==DEBOUNCE_CYCLES -> IDLE. Else cnt++.
  - Exactly one event per press, however long the sensor is held.
- Latency: raw held high from sampling edge k, unblocked -> output pulse high for the one cycle after edge k+DEBOUNCE_CYCLES+2.
- Output and slot logic, all outputs registered:
  - Both events in the same cycle: coin_reject=1; neither coin is issued or stored.
  - Single event, dispense=0, slot empty: pulse the matching output next cycle.
  - Single event, dispense=1, slot empty: store the type in the slot; pending=1.
  - Single event, slot full: coin_reject=1; the new coin is dropped and the held coin is kept.
  - Slot full and dispense=0: emit the held type and clear the slot.
  - If a new event arrives in the same cycle the slot empties, the new coin is stored, not rejected (pending stays 1).
- coin5 and coin10 are never high together. Any output pulse lasts exactly one cycle.
- Counter never exceeds DEBOUNCE_CYCLES. No wrap-around.

Optional Feature:
COIN_AUDIT_EN
- Defined: adds output ports total5 [7:0], total10 [7:0] and rejects [7:0]. These are saturating counts of issued coin5 pulses, issued coin10 pulses and coin_reject pulses. They hold at 255, reset to 0 on rst, and increment in the cycle the corresponding output pulse is high.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Clean press (DEBOUNCE_CYCLES=4): coin5_raw high from edge 10 for 20 cycles, dispense=0 -> coin5 high only the cycle after edge 16; coin10 and coin_reject stay 0; a single pulse for the whole hold.
- Bounce: coin10_raw toggles 1,0,1,1,0 then steady high -> no pulse during bouncing; exactly one coin10 pulse 4 stable cycles + 2 sync cycles after the final rise; re-press accepted only after 4 stable-low cycles.
- Hold during dispense: dispense=1, coin10 accepted -> pending=1, no coin10. Drop dispense -> coin10 pulse the next cycle, pending=0.
- Overflow: dispense=1, coin5 accepted then coin10 accepted -> coin_reject one cycle on the second coin. Release dispense -> coin5 is issued.
- Simultaneous: both raw inputs rise on the same edge -> coin_reject one cycle, no coin pulse, slot unchanged.
- Reset mid-op: rst pulsed while PRESS_CHK cnt=2 and slot full -> all outputs 0, pending=0. A still-high sensor needs a full 4-cycle debounce after release of rst before coin5 or coin10 pulses.
